// File: rtl/tensor_core_pkg.sv
// Shared tensor core types: matrix geometry, byte and matrix typedefs,
// and the result serializer state encoding.
package tensor_core_pkg;

    localparam int MATRIX_DIM          = 4;
    localparam int ELEMENTS_PER_MATRIX = MATRIX_DIM * MATRIX_DIM;

    typedef logic [7:0] tc_byte_t;
    typedef tc_byte_t matrix_t [MATRIX_DIM][MATRIX_DIM];

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } serializer_state_t;

endpackage

// File: rtl/tensor_core_result_serializer_if.sv
// Byte-serial readout stream of the tensor core result serializer.
//
// Handshake: the master presents data_out/address_out/last_out with
// valid_out high; a byte transfers on a rising clock edge where both
// valid_out and ready_in are high. While valid_out is high and ready_in is
// low the master holds data_out, address_out and last_out stable. ready_in
// is ignored while valid_out is low. last_out marks the final byte of a load.
interface tensor_core_result_serializer_if #(
    parameter int ADDR_WIDTH = 5
) ();

    logic [7:0]            data_out;
    logic [ADDR_WIDTH-1:0] address_out;
    logic                  valid_out;
    logic                  ready_in;
    logic                  last_out;

    modport master (
        output data_out,
        output address_out,
        output valid_out,
        output last_out,
        input  ready_in
    );

    modport slave (
        input  data_out,
        input  address_out,
        input  valid_out,
        input  last_out,
        output ready_in
    );

endinterface

// File: rtl/tensor_core_result_serializer.sv
// Captures NUMBER_OF_MATRICES 4x4 byte matrices in one cycle and streams
// them out one byte per handshake in ascending flat address order.
// Flat address a maps to matrix a/16, row (a%16)/4, column a%4.
module tensor_core_result_serializer
    import tensor_core_pkg::*;
#(
    parameter int NUMBER_OF_MATRICES = 2
) (
    input  logic                            clock_in,
    input  logic                            reset_n_in,
    input  logic                            load_in,
    input  matrix_t                         matrix_data_in [NUMBER_OF_MATRICES],
    output logic                            busy_out,
    output logic                            done_out,
    output serializer_state_t               state_dbg_out,
    tensor_core_result_serializer_if.master stream
);

    localparam int TOTAL_ELEMENTS = NUMBER_OF_MATRICES * ELEMENTS_PER_MATRIX;
    localparam int ADDR_WIDTH     = (TOTAL_ELEMENTS > 1) ? $clog2(TOTAL_ELEMENTS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(TOTAL_ELEMENTS - 1);

    serializer_state_t     state_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic                  done_q;
    matrix_t               shadow_q [NUMBER_OF_MATRICES];
    tc_byte_t              shadow_flat [TOTAL_ELEMENTS];
    logic                  streaming;

    // Flat, named view of every captured byte; also the read mux source.
    for (genvar g = 0; g < TOTAL_ELEMENTS; g++) begin : g_shadow_view
        tc_byte_t shadow_byte;
        assign shadow_byte    = shadow_q[g / ELEMENTS_PER_MATRIX]
                                        [(g % ELEMENTS_PER_MATRIX) / MATRIX_DIM]
                                        [g % MATRIX_DIM];
        assign shadow_flat[g] = shadow_byte;
    end

    // FSM, index counter and shadow capture; shadow only changes on load.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
            index_q <= '0;
            done_q  <= 1'b0;
            for (int m = 0; m < NUMBER_OF_MATRICES; m++) begin
                for (int r = 0; r < MATRIX_DIM; r++) begin
                    for (int c = 0; c < MATRIX_DIM; c++) begin
                        shadow_q[m][r][c] <= '0;
                    end
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_in) begin
                        shadow_q <= matrix_data_in;
                        index_q  <= '0;
                        state_q  <= STREAM;
                    end
                end
                STREAM: begin
                    if (stream.ready_in) begin
                        if (index_q == LAST_INDEX) begin
                            state_q <= IDLE;
                            index_q <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            index_q <= index_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs depend only on registered state, never on ready_in or load_in.
    always_comb begin
        streaming          = (state_q == STREAM);
        stream.valid_out   = streaming;
        stream.address_out = index_q;
        stream.data_out    = streaming ? shadow_flat[index_q] : 8'h00;
        stream.last_out    = streaming && (index_q == LAST_INDEX);
        busy_out           = streaming;
        done_out           = done_q;
        state_dbg_out      = state_q;
    end

endmodule

// File: doc/tensor_core_result_serializer.md
# tensor_core_result_serializer

Captures the full parallel contents of one or more 4x4 byte matrices in a single cycle and streams them out one byte per handshake, each byte tagged with its flat register address. It is the read-back counterpart of the tensor core register file write port: it turns a tensor core's parallel result into the byte-serial address/data stream the host side consumes. It sits between the tensor core output and the host readout path.

## Interface
Parameters:
- NUMBER_OF_MATRICES, default 2: number of 4x4 matrices captured per load. Must be at least 1.
- TOTAL_ELEMENTS, derived, equals NUMBER_OF_MATRICES*16: bytes streamed per load.

Ports:
- clock_in  input  1  sole clock; all logic is on its rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- load_in  input  1  capture request; sampled only in IDLE.
- matrix_data_in  input  8 x [NUMBER_OF_MATRICES][4][4]  parallel matrix contents.
- busy_out  output  1  high while not in IDLE.
- data_out  output  8  current byte.
- address_out  output  $clog2(TOTAL_ELEMENTS) (minimum 1)  flat address of data_out.
- valid_out  output  1  data_out and address_out are valid.
- ready_in  input  1  consumer accepts the byte when valid_out && ready_in.
- last_out  output  1  high with the final byte of a load.
- done_out  output  1  one-cycle pulse after the final byte is accepted.

## Operation
- States:
  - IDLE: valid_out=0, busy_out=0. If load_in=1, snapshot all of matrix_data_in into the shadow buffer, set index=0, go to STREAM.
  - STREAM: valid_out=1, busy_out=1. data_out = shadow[index/16][(index%16)/4][index%4]; address_out = index.
  - On a handshake with index < TOTAL_ELEMENTS-1: index increments.
  - On a handshake with index = TOTAL_ELEMENTS-1: go to IDLE and pulse done_out next cycle.
- last_out = valid_out && (index == TOTAL_ELEMENTS-1).
- Stream order is ascending flat address. The address→[m][row][col] mapping is m = a/16, row = (a%16)/4, col = a%4.
- The shadow buffer is frozen during STREAM. Changes on matrix_data_in after capture do not affect output.
- load_in is ignored while in STREAM. There is no queueing of load requests.
- Backpressure: while valid_out=1 and ready_in=0, data_out, address_out and last_out hold stable.
- ready_in while valid_out=0 has no effect.

## Timing
- Reset values (asynchronous, immediate on reset_n_in low): state=IDLE, index=0, and all outputs 0. This includes data_out, address_out, valid_out, last_out, done_out and busy_out. The shadow buffer is reset to 0.
- Load latency: load_in sampled high at edge N → valid_out=1 with address 0 after edge N (visible in cycle N+1).
- Throughput: 1 byte/cycle when ready_in is held high. A load completes in TOTAL_ELEMENTS cycles of valid_out.
- Final handshake at edge M → after edge M: valid_out=0, busy_out=0, done_out=1 for exactly one cycle.
- A load_in sampled at edge M+1 (during the done_out cycle, state IDLE) is accepted. Minimum gap between streams is one idle cycle.
- A load_in high during the final-handshake cycle is ignored, because the block is still in STREAM.
- Reset mid-stream aborts the transfer immediately. done_out is not asserted for the aborted load.
- All outputs are registered, or are combinational from registered state only (last_out). There is no combinational path from ready_in or load_in to any output.

## Structure
- Shared package tensor_core_pkg holds:
  - MATRIX_DIM = 4
  - ELEMENTS_PER_MATRIX = 16
  - typedef tc_byte_t as logic [7:0]
  - typedef matrix_t as tc_byte_t [MATRIX_DIM][MATRIX_DIM]
  - enum serializer_state_t {IDLE, STREAM}
- Single module; no sub-module is needed. The shadow buffer, index counter and FSM live in one file.
- Expose each shadow register as a named wire in a generate block for waveform visibility.

## Test plan
- Reset then idle: hold reset_n_in low, release, wait 5 cycles with load_in=0 → all outputs stay 0.
- Basic stream, NUMBER_OF_MATRICES=2: fill element i with value i+8'h10, pulse load_in, ready_in=1.
  - Bytes 8'h10..8'h2F appear on consecutive cycles with address_out 0..31.
  - last_out is high only on address 31.
  - done_out pulses one cycle later.
- Backpressure: same load, ready_in low on every odd cycle → data/address held while stalled, all 32 bytes delivered in order with no duplicates.
- Snapshot isolation: change matrix_data_in to all 8'hFF one cycle after load → streamed values remain the captured ones.
- Load during stream: pulse load_in at address 5 and again during the final-handshake cycle → both ignored, only 32 bytes emitted. A load_in in the done_out cycle starts a new stream at address 0.
- Reset mid-stream: assert reset_n_in at address 12 → outputs 0 immediately, no done_out. After release and a new load, streaming restarts at address 0.
